// File: rtl/mux4_sched_pkg.sv
// Shared types and constants for the four-source round-robin mux scheduler.
package mux4_sched_pkg;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ptr+3, ptr and returns
// the first requesting source.
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] winner
);

    logic [SEL_W-1:0] idx;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        any    = |req;
        winner = '0;
        idx    = '0;
        for (int off = N_SRC; off >= 1; off--) begin
            idx = ptr + SEL_W'(off);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler sharing one 4:1 data mux between four requesters, with
// bursts of up to MAX_BURST beats per grant and a one-cycle arbitration bubble.
module mux4_rr_scheduler
    import mux4_sched_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic             busy
);

    localparam int unsigned      CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_winner;
    logic             xfer;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign busy      = (state_q == StGrant);
    assign out_valid = busy & req[sel_q];
    assign xfer      = out_valid & out_ready;
    assign sel       = sel_q;
    assign grant     = grant_q;

    always_comb begin
        out_data = d0;
        unique case (sel_q)
            2'd0: out_data = d0;
            2'd1: out_data = d1;
            2'd2: out_data = d2;
            2'd3: out_data = d3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StGrant;
                    sel_d   = pick_winner;
                    grant_d = 4'b0001 << pick_winner;
                    beat_d  = '0;
                end
            end
            StGrant: begin
                // Owner withdrawing or finishing its burst drops to lowest priority.
                if (!req[sel_q] || (xfer && beat_q == LAST_BEAT)) begin
                    state_d = StIdle;
                    ptr_d   = sel_q;
                    grant_d = '0;
                    beat_d  = '0;
                end else if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ptr_q   <= 2'd3;
            grant_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Scoreboard bench: directed stimulus queues expected {grant, data} per beat,
// monitors pop and compare on every accepted transfer.
module tb_mux4_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, rst1_n;
    logic [3:0] req, req1;
    logic [7:0] d0, d1, d2, d3;
    logic       out_ready, ready1;
    logic       out_valid, valid1;
    logic [7:0] out_data, data1;
    logic [1:0] sel, sel1;
    logic [3:0] grant, grant1;
    logic       busy, busy1;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [11:0] exp1_q[$];

    always #5 clk = ~clk;

    mux4_rr_scheduler #(.W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .grant     (grant),
        .busy      (busy)
    );

    mux4_rr_scheduler #(.W(8), .MAX_BURST(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst1_n),
        .req       (req1),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_ready (ready1),
        .out_valid (valid1),
        .out_data  (data1),
        .sel       (sel1),
        .grant     (grant1),
        .busy      (busy1)
    );

    function automatic logic [7:0] src_data(input int s);
        case (s)
            0:       return 8'hA5;
            1:       return 8'hB1;
            2:       return 8'hC2;
            default: return 8'hD3;
        endcase
    endfunction

    function automatic logic [11:0] beat(input int s);
        logic [3:0] oh;
        oh = 4'b0001 << s;
        return {oh, src_data(s)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Monitors: every accepted beat must match the next queued expectation.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer: unexpected beat grant=%b data=%h at %0t", grant, out_data,
                         $time);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({grant, out_data} !== e) begin
                    errors++;
                    $display("FAIL xfer: got grant=%b data=%h expected grant=%b data=%h at %0t",
                             grant, out_data, e[11:8], e[7:0], $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (valid1 && ready1) begin
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL xfer1: unexpected beat grant=%b data=%h at %0t", grant1, data1,
                         $time);
            end else begin
                logic [11:0] e;
                e = exp1_q.pop_front();
                if ({grant1, data1} !== e) begin
                    errors++;
                    $display("FAIL xfer1: got grant=%b data=%h expected grant=%b data=%h at %0t",
                             grant1, data1, e[11:8], e[7:0], $time);
                end
            end
        end
    end

    initial begin
        d0 = src_data(0);
        d1 = src_data(1);
        d2 = src_data(2);
        d3 = src_data(3);
        rst1_n = 1'b0;
        req1   = 4'b0000;
        ready1 = 1'b0;

        // Reset state
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        step();
        check("rst_grant", grant, 4'b0000);
        check("rst_sel", sel, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'hA5);
        step();
        rst_n = 1'b1;

        // Single requester: 4-beat burst, one idle cycle, re-grant
        req = 4'b0001;
        out_ready = 1'b1;
        repeat (4) exp_q.push_back(beat(0));
        check("t1_pre_grant", grant, 4'b0000);
        step();
        check("t1_grant", grant, 4'b0001);
        check("t1_busy", busy, 1'b1);
        check("t1_valid", out_valid, 1'b1);
        repeat (3) step();
        check("t1_busy_b3", busy, 1'b1);
        step();
        check("t1_release", grant, 4'b0000);
        check("t1_idle", busy, 1'b0);
        step();
        check("t1_regrant", grant, 4'b0001);
        req = 4'b0000;
        step();
        check("t1_withdraw", busy, 1'b0);

        // All four requesting: order 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        req = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            repeat (4) exp_q.push_back(beat(k % 4));
        end
        step();
        for (int k = 0; k < 5; k++) begin
            check("t2_grant", grant, 32'(4'b0001 << (k % 4)));
            check("t2_sel", sel, 32'(k % 4));
            repeat (4) step();
            check("t2_bubble", busy, 1'b0);
            if (k == 4) req = 4'b0000;
            step();
        end

        // Backpressure holds the grant without counting beats
        do_reset();
        req = 4'b0100;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t3_grant", grant, 4'b0100);
            check("t3_sel", sel, 2'd2);
            check("t3_valid", out_valid, 1'b1);
            check("t3_data", out_data, 8'hC2);
            step();
        end
        out_ready = 1'b1;
        repeat (4) exp_q.push_back(beat(2));
        repeat (3) step();
        check("t3_busy_b3", busy, 1'b1);
        step();
        check("t3_release", grant, 4'b0000);
        req = 4'b0000;
        step();

        // Owner withdraws after two beats; waiting source 3 follows
        do_reset();
        req = 4'b1010;
        out_ready = 1'b1;
        repeat (2) exp_q.push_back(beat(1));
        repeat (4) exp_q.push_back(beat(3));
        step();
        check("t4_grant1", grant, 4'b0010);
        repeat (2) step();
        check("t4_busy_b2", busy, 1'b1);
        req = 4'b1000;
        step();
        check("t4_release", grant, 4'b0000);
        check("t4_idle", busy, 1'b0);
        step();
        check("t4_grant3", grant, 4'b1000);
        check("t4_sel3", sel, 2'd3);
        repeat (4) step();
        check("t4_release3", busy, 1'b0);
        req = 4'b0000;
        step();

        // Reset mid-burst aborts immediately
        do_reset();
        req = 4'b0001;
        out_ready = 1'b1;
        repeat (2) exp_q.push_back(beat(0));
        step();
        check("t5_grant0", grant, 4'b0001);
        repeat (2) step();
        rst_n = 1'b0;
        req = 4'b1000;
        #1;
        check("t5_rst_grant", grant, 4'b0000);
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_data", out_data, 8'hA5);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) exp_q.push_back(beat(3));
        step();
        check("t5_grant3", grant, 4'b1000);
        repeat (4) step();
        check("t5_release", busy, 1'b0);
        req = 4'b0000;
        step();

        // MAX_BURST=1: single beat per grant, alternating 0,2,0,2
        req1 = 4'b0101;
        ready1 = 1'b1;
        rst1_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp1_q.push_back(beat((k % 2) * 2));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_grant", grant1, 32'((k % 2 == 0) ? 4'b0001 : 4'b0100));
            step();
            check("t6_idle", busy1, 1'b0);
            if (k == 3) req1 = 4'b0000;
        end
        repeat (2) step();

        check("drain_q", exp_q.size(), 0);
        check("drain_q1", exp1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_scheduler.md
Name: mux4_rr_scheduler

Overview:
Round-robin scheduler that shares one 4:1 datapath mux between four requesters. It arbitrates among req[3:0] and drives the mux select. It forwards the granted source's data to a single valid/ready output port, holding the grant for a burst of up to MAX_BURST beats. It sits in front of any consumer that must be time-shared by four producers.

Parameters:
W, 8, data width of each source and of out_data (W >= 1)
MAX_BURST, 4, max beats transferred per grant before forced release (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  per-source request; source i holds req[i] high while it has a beat to send
d0  input  W  source 0 data
d1  input  W  source 1 data
d2  input  W  source 2 data
d3  input  W  source 3 data
out_ready  input  1  consumer accepts out_data this cycle
out_valid  output  1  out_data is valid
out_data  output  W  selected source data
sel  output  2  current mux select (registered)
grant  output  4  one-hot grant to the owning source (registered); beat from source i consumed when grant[i] & out_valid & out_ready
busy  output  1  high in GRANT state

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sel=0, grant=0, ptr=3, beat_cnt=0, busy=0. Outputs during reset: out_valid=0, out_data=d0. Reset mid-burst aborts the burst; no beat is counted.
- Two states: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit of req scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - On the next edge: sel=winner, grant=onehot(winner), beat_cnt=0, state=GRANT.
- Latency: req rising to grant high is 1 cycle. There is always at least one IDLE cycle between consecutive grants (arbitration bubble).
- GRANT:
  - out_valid = req[sel], combinational.
  - out_data = d[sel] via 4:1 select, combinational. out_data is don't-care when out_valid=0, but is still driven as d[sel].
  - Transfer = out_valid & out_ready. Each transfer increments beat_cnt.
- Release to IDLE, with ptr=sel, grant=0, beat_cnt=0 on the edge, when either:
  - (a) req[sel]==0 in a cycle (owner withdrew; no transfer that cycle), or
  - (b) a transfer occurs with beat_cnt==MAX_BURST-1.
  - Otherwise remain in GRANT.
- Backpressure: out_ready low holds everything. The grant is kept, out_data stays d[sel], and beat_cnt is unchanged. Sources must keep data stable while req is high and the beat is not consumed.
- Simultaneous events:
  - Requests arriving for other sources during GRANT are ignored until the next IDLE.
  - If the owner's req drops in the same cycle out_ready rises, no transfer occurs; release.
- Fairness: after a release the owner has lowest priority. Any source continuously requesting is granted within 3 grants.
- beat_cnt width is clog2(MAX_BURST) bits, minimum 1. No wrap occurs because release happens at MAX_BURST-1.
- MAX_BURST=1: release after every transfer.
- Single requester: alternates GRANT(burst) / IDLE(1 cycle).

Decomposition:
- Package mux4_sched_pkg:
  - state typedef (IDLE, GRANT)
  - N_SRC=4
  - SEL_W=2
- Sub-module rr_pick4: combinational round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, winner[1:0].
- FSM, counters and the W-bit 4:1 select stay in the top.

Test Plan:
1. Reset, then req=0001, out_ready=1, d0=8'hA5 -> grant=0001 one cycle later; out_valid=1, out_data=A5 for 4 beats; release; ptr=0; one IDLE cycle; re-grant to 0.
2. req=1111 held, out_ready=1, MAX_BURST=4 -> grant order 0,1,2,3,0; each grant lasts 4 transfer cycles separated by 1 IDLE cycle.
3. Owner 2 granted, out_ready=0 for 5 cycles -> grant=0100, sel=2, beat_cnt stays 0, out_valid=1; then out_ready=1 -> 4 transfers then release.
4. Owner 1 granted; req[1] drops after 2 transfers while req[3]=1 -> release at the drop, grant to 3 after 1 IDLE cycle, ptr=1.
5. Assert rst_n=0 mid-burst (beat_cnt=2) -> immediately grant=0, out_valid=0, busy=0. After release with req=1000 -> winner is 0's successor scan from ptr=3, granting 3.
6. MAX_BURST=1, req=0101, out_ready=1 -> grants alternate 0,2,0,2 with 1 transfer each.
